// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator and instruction-bus requester.
//
// Owns the fetch PC and keeps at most one instruction-bus request in flight.
// The request address is held stable until iresp_data_ok. Redirects come in
// on N_REDIRECT prioritised channels (index 0 highest). A redirect that lands
// while a request is in flight parks the target in pending_pc and waits in
// KILL for the stale response, which is then dropped. Returned instructions
// are placed in an output register, with a one-entry hold buffer behind it so
// that a response arriving during a decode stall is not lost.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   defined   - a misaligned PC is not fetched; one {pc, 0, misaligned=1}
//               marker is delivered and fetch stops until the next redirect.
//   undefined - fetch_misaligned stays 0 and ireq_addr has its low
//               log2(INST_BYTES) bits cleared.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   stall              decode cannot accept this cycle
//   redirect_valid/pc  per-channel redirect; channel i at [i*PC_WIDTH +: PC_WIDTH]
//   ireq_valid/addr    instruction-bus request
//   iresp_data_ok/data instruction-bus response (completes the request)
//   pc                 registered fetch PC
//   fetch_valid/pc/inst/misaligned  entry presented to decode
module fetch_pc_unit #(
  parameter int                  PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(64'h8000_0000),
  parameter int                  INST_BYTES = 4,
  parameter int                  N_REDIRECT = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [N_REDIRECT-1:0]          redirect_valid,
  input  logic [N_REDIRECT*PC_WIDTH-1:0] redirect_pc,
  output logic                           ireq_valid,
  output logic [PC_WIDTH-1:0]            ireq_addr,
  input  logic                           iresp_data_ok,
  input  logic [31:0]                    iresp_data,
  output logic [PC_WIDTH-1:0]            pc,
  output logic                           fetch_valid,
  output logic [PC_WIDTH-1:0]            fetch_pc,
  output logic [31:0]                    fetch_inst,
  output logic                           fetch_misaligned
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INST_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INST_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pending_pc;

  logic                redir_any;
  logic [PC_WIDTH-1:0] redir_tgt;

  logic                new_valid;
  logic [PC_WIDTH-1:0] new_pc;
  logic [31:0]         new_inst;
  logic                new_mis;

  logic                out_valid;
  logic [PC_WIDTH-1:0] out_pc;
  logic [31:0]         out_inst;
  logic                out_mis;

  logic                hold_valid;
  logic [PC_WIDTH-1:0] hold_pc;
  logic [31:0]         hold_inst;
  logic                hold_mis;

  logic                out_load;
  logic                hold_load;
  logic                hold_drain;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                pc_misaligned;
  logic                mis_sent;

  assign pc_misaligned = (pc & ALIGN_MASK) != '0;
  assign ireq_addr     = pc;
`else
  assign ireq_addr     = pc & ~ALIGN_MASK;
`endif

  // Redirect select: scan from the top so the lowest asserted index wins.
  always_comb begin
    redir_any = |redirect_valid;
    redir_tgt = '0;
    for (int i = N_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) redir_tgt = redirect_pc[i*PC_WIDTH +: PC_WIDTH];
    end
  end

  // Entry produced this cycle: a bus response in REQ, or a misaligned marker.
  always_comb begin
    new_valid = 1'b0;
    new_pc    = pc;
    new_inst  = iresp_data;
    new_mis   = 1'b0;
    if (!redir_any) begin
      if (state == S_REQ && iresp_data_ok) begin
        new_valid = 1'b1;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (state == S_IDLE && !hold_valid && pc_misaligned && !mis_sent) begin
        new_valid = 1'b1;
        new_inst  = '0;
        new_mis   = 1'b1;
      end
`endif
    end
  end

  // Hold is only written when the output is occupied and decode is stalled.
  // A new entry and a hold drain never coincide: requests start only with
  // the hold buffer empty.
  assign out_load   = new_valid && (!out_valid || !stall);
  assign hold_load  = new_valid && out_valid && stall;
  assign hold_drain = !redir_any && !new_valid && !stall && hold_valid;

  // ---- Fetch FSM: PC, pending redirect target, request valid ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ireq_valid <= 1'b0;
      pc         <= RESET_PC;
      pending_pc <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_sent   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (redir_any) begin
            pc <= redir_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_sent <= 1'b0;
`endif
          end else if (!hold_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            // Misaligned PC: marker goes out once, PC stays frozen.
            if (pc_misaligned) begin
              mis_sent <= 1'b1;
            end else begin
              state      <= S_REQ;
              ireq_valid <= 1'b1;
            end
`else
            state      <= S_REQ;
            ireq_valid <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (redir_any) begin
            if (iresp_data_ok) begin
              pc         <= redir_tgt;
              state      <= S_IDLE;
              ireq_valid <= 1'b0;
            end else begin
              // Keep the old address on the bus until the stale response returns.
              pending_pc <= redir_tgt;
              state      <= S_KILL;
            end
          end else if (iresp_data_ok) begin
            pc <= pc + PC_STEP;
            if (hold_load) begin
              state      <= S_IDLE;
              ireq_valid <= 1'b0;
            end
          end
        end
        S_KILL: begin
          if (iresp_data_ok) begin
            pc         <= redir_any ? redir_tgt : pending_pc;
            state      <= S_IDLE;
            ireq_valid <= 1'b0;
          end else if (redir_any) begin
            pending_pc <= redir_tgt;
          end
        end
        default: begin
          state      <= S_IDLE;
          ireq_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---- Output register and hold-buffer occupancy ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_mis    <= 1'b0;
      hold_valid <= 1'b0;
    end else if (redir_any) begin
      out_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_pc    <= new_pc;
      out_inst  <= new_inst;
      out_mis   <= new_mis;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
    end else if (hold_drain) begin
      out_valid  <= 1'b1;
      out_pc     <= hold_pc;
      out_inst   <= hold_inst;
      out_mis    <= hold_mis;
      hold_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

  // ---- Hold-buffer payload (qualified by hold_valid) ----
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_pc   <= new_pc;
      hold_inst <= new_inst;
      hold_mis  <= new_mis;
    end
  end

  assign fetch_valid      = out_valid;
  assign fetch_pc         = out_pc;
  assign fetch_inst       = out_inst;
  assign fetch_misaligned = out_mis;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model
// (architectural next-fetch PC, kill flag, queue of undelivered entries).
module tb_fetch_pc_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [63:0] ADDR_MASK = '1;
`else
  localparam logic [63:0] ADDR_MASK = ~64'h3;
`endif

  logic         clk;
  logic         reset;
  logic         stall;
  logic [1:0]   redirect_valid;
  logic [127:0] redirect_pc;
  logic         ireq_valid;
  logic [63:0]  ireq_addr;
  logic         iresp_data_ok;
  logic [31:0]  iresp_data;
  logic [63:0]  pc;
  logic         fetch_valid;
  logic [63:0]  fetch_pc;
  logic [31:0]  fetch_inst;
  logic         fetch_misaligned;

  fetch_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .ireq_valid       (ireq_valid),
    .ireq_addr        (ireq_addr),
    .iresp_data_ok    (iresp_data_ok),
    .iresp_data       (iresp_data),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_inst       (fetch_inst),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model state
  logic [63:0] arch_pc;      // where sequential fetch continues
  logic [63:0] killed_addr;  // address of a request whose response will be dropped
  bit          killed;
  ent_t        q[$];         // entries handed to the DUT but not yet taken by decode
  logic [63:0] obs_pc[$];    // fetch_pc values taken by decode
  int          idle_run;
  bit          model_on;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    arch_pc  = RST_PC;
    killed   = 1'b0;
    killed_addr = '0;
    q.delete();
    idle_run = 0;
  endtask

  // One clock: drive inputs at the negedge, check outputs, advance the model.
  task automatic step(input bit stl, input logic [1:0] rv, input logic [63:0] t0,
                      input logic [63:0] t1, input bit dok, input logic [31:0] d);
    logic [63:0] exp_pc;
    logic [63:0] tgt;
    bit          dok_eff;
    dok_eff        = dok && ireq_valid;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = {t1, t0};
    iresp_data_ok  = dok_eff;
    iresp_data     = d;
    if (model_on) begin
      exp_pc = killed ? killed_addr : arch_pc;
      chk("fetch_valid", fetch_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("fetch_pc", fetch_pc, q[0].pc);
        chk("fetch_inst", fetch_inst, q[0].inst);
      end
      chk("fetch_misaligned", fetch_misaligned, 0);
      chk("pc", pc, exp_pc);
      if (ireq_valid) chk("ireq_addr", ireq_addr, exp_pc & ADDR_MASK);
      if (q.size() == 2) chk("no_req_hold_full", ireq_valid, 0);
      if (ireq_valid || q.size() == 2) idle_run = 0;
      else idle_run++;
      chk("req_liveness", idle_run <= 2, 1);

      if (fetch_valid && !stl) begin
        obs_pc.push_back(fetch_pc);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (rv != 2'b00) begin
        tgt = rv[0] ? t0 : t1;
        q.delete();
        if (ireq_valid && !dok_eff) begin
          if (!killed) begin
            killed      = 1'b1;
            killed_addr = arch_pc;
          end
        end else begin
          killed = 1'b0;
        end
        arch_pc  = tgt;
        idle_run = 0;
      end else if (ireq_valid && dok_eff) begin
        if (killed) killed = 1'b0;
        else begin
          q.push_back('{pc: arch_pc, inst: d});
          arch_pc = arch_pc + 64'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 8 && !ireq_valid; i++) idle_step();
    chk(tag, ireq_valid, 1);
  endtask

  task automatic do_reset();
    stall = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit          r_stl;
    logic [1:0]  r_rv;
    logic [63:0] r_t0, r_t1;
    model_on = 1'b1;
    stall = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    chk("rst_fetch_inst", fetch_inst, 0);
    chk("rst_fetch_mis", fetch_misaligned, 0);
    chk("rst_pc", pc, RST_PC);
    reset = 1'b0;
    model_reset();

    // Sequential fetch, data_ok one cycle after each request
    idle_step();
    chk("t1_first_req_valid", ireq_valid, 1);
    chk("t1_first_req_addr", ireq_addr, 64'h8000_0000);
    obs_pc.delete();
    repeat (4) step(1'b0, 2'b00, 64'h0, 64'h0, 1'b1, $urandom);
    chk("t1_count", obs_pc.size() >= 3, 1);
    if (obs_pc.size() >= 3) begin
      chk("t1_pc0", obs_pc[0], 64'h8000_0000);
      chk("t1_pc1", obs_pc[1], 64'h8000_0004);
      chk("t1_pc2", obs_pc[2], 64'h8000_0008);
    end

    // Redirect ch1 two cycles into a request to 0x8000_0004
    do_reset();
    obs_pc.delete();
    idle_step();
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b1, 32'h1111_0000);
    chk("t2_req4_addr", ireq_addr, 64'h8000_0004);
    idle_step();
    step(1'b0, 2'b10, 64'h0, 64'h8000_1000, 1'b0, 32'h0);
    repeat (2) begin
      chk("t2_kill_valid", ireq_valid, 1);
      chk("t2_kill_addr", ireq_addr, 64'h8000_0004);
      idle_step();
    end
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b1, 32'h2222_0000);
    wait_req("t2_req_seen");
    chk("t2_new_addr", ireq_addr, 64'h8000_1000);
    repeat (2) idle_step();
    found = 1'b0;
    foreach (obs_pc[i]) if (obs_pc[i] == 64'h8000_0004) found = 1'b1;
    chk("t2_no_fetch_4", found, 0);

    // Both channels in the same cycle: channel 0 wins
    step(1'b0, 2'b11, 64'h8000_2000, 64'h8000_3000, 1'b0, 32'h0);
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b1, 32'h3333_0000);
    wait_req("t3_req_seen");
    chk("t3_prio_addr", ireq_addr, 64'h8000_2000);

    // Stall: second response goes to the hold buffer, requests pause
    obs_pc.delete();
    step(1'b1, 2'b00, 64'h0, 64'h0, 1'b1, 32'hA000_0001);
    step(1'b1, 2'b00, 64'h0, 64'h0, 1'b1, 32'hA000_0002);
    repeat (3) begin
      chk("t4_stall_no_req", ireq_valid, 0);
      chk("t4_stall_out_pc", fetch_pc, 64'h8000_2000);
      step(1'b1, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
    end
    idle_step();
    idle_step();
    wait_req("t4_resume");
    chk("t4_resume_addr", ireq_addr, 64'h8000_2008);
    chk("t4_order_count", obs_pc.size(), 2);
    if (obs_pc.size() >= 2) begin
      chk("t4_order0", obs_pc[0], 64'h8000_2000);
      chk("t4_order1", obs_pc[1], 64'h8000_2004);
    end

    // Asynchronous reset while in KILL with pending 0x8000_4000
    step(1'b0, 2'b01, 64'h8000_4000, 64'h0, 1'b0, 32'h0);
    idle_step();
    chk("t5_in_kill", ireq_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ireq_valid", ireq_valid, 0);
    chk("t5_rst_fetch_valid", fetch_valid, 0);
    chk("t5_rst_fetch_pc", fetch_pc, 0);
    chk("t5_rst_fetch_inst", fetch_inst, 0);
    chk("t5_rst_pc", pc, RST_PC);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_step();
    chk("t5_first_req_valid", ireq_valid, 1);
    chk("t5_first_req_addr", ireq_addr, 64'h8000_0000);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r_stl = ($urandom_range(0, 9) < 3);
      r_rv  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_t0  = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
      r_t1  = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
      step(r_stl, r_rv, r_t0, r_t1, $urandom_range(0, 9) < 4, $urandom);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect produces one marker and no bus request
    model_on = 1'b0;
    do_reset();
    step(1'b0, 2'b01, 64'h8000_0002, 64'h0, 1'b0, 32'h0);
    idle_step();
    chk("fa_no_req", ireq_valid, 0);
    chk("fa_valid", fetch_valid, 1);
    chk("fa_mis", fetch_misaligned, 1);
    chk("fa_pc", fetch_pc, 64'h8000_0002);
    chk("fa_inst", fetch_inst, 0);
    repeat (3) begin
      idle_step();
      chk("fa_frozen_no_req", ireq_valid, 0);
      chk("fa_single_marker", fetch_valid, 0);
      chk("fa_frozen_pc", pc, 64'h8000_0002);
    end
    step(1'b0, 2'b01, 64'h8000_0100, 64'h0, 1'b0, 32'h0);
    wait_req("fa_resume");
    chk("fa_resume_addr", ireq_addr, 64'h8000_0100);
`else
    // Misaligned redirect: low address bits cleared on the bus, no marker
    do_reset();
    step(1'b0, 2'b01, 64'h8000_0002, 64'h0, 1'b0, 32'h0);
    wait_req("na_req_seen");
    chk("na_addr_masked", ireq_addr, 64'h8000_0000);
    chk("na_pc", pc, 64'h8000_0002);
    step(1'b0, 2'b00, 64'h0, 64'h0, 1'b1, 32'h5555_AAAA);
    chk("na_fetch_pc", fetch_pc, 64'h8000_0002);
    chk("na_no_mis", fetch_misaligned, 0);
    idle_step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
